// File: rtl/eth_mii_gearbox.sv
// PHY-symbol <-> byte gearbox between a byte-wide MAC and an MII/RMII data path.
// The RX side aligns on the SFD and assembles bytes. The TX side serialises
// bytes LSB-symbol first and flags underflow.
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for rx_dv
//   RX_PRE   | hunting preamble symbols for the SFD-end symbol
//   RX_DATA  | assembling bytes; one completed byte is held until the next one or frame end
//   RX_DROP  | bad preamble seen; discard until rx_dv falls
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | no byte loaded; ready for the first byte of a frame
//   TX_SHIFT | driving the symbols of the loaded byte
//   TX_ERR   | underflow: one error symbol goes out on the next enable
//   TX_DRAIN | aborted frame: accept and drop bytes until one flagged last
module eth_mii_gearbox #(
  parameter int PHY_WIDTH = 4,
  parameter bit ALIGN_SFD = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 rx_ce_i,
  input  logic [PHY_WIDTH-1:0] phy_rxd_i,
  input  logic                 phy_rx_dv_i,
  input  logic                 phy_rx_er_i,
  output logic [7:0]           rx_byte_o,
  output logic                 rx_valid_o,
  output logic                 rx_last_o,
  output logic                 rx_err_o,
  output logic                 rx_align_err_o,
  input  logic                 tx_ce_i,
  input  logic [7:0]           tx_byte_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  logic                 tx_last_i,
  input  logic                 tx_err_i,
  output logic [PHY_WIDTH-1:0] phy_txd_o,
  output logic                 phy_tx_en_o,
  output logic                 phy_tx_er_o,
  output logic                 tx_underflow_o
);

  localparam int N  = 8 / PHY_WIDTH;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [PHY_WIDTH-1:0] PRE_SYM = PRE_BYTE[PHY_WIDTH-1:0];
  localparam logic [PHY_WIDTH-1:0] SFD_SYM = SFD_BYTE[7 -: PHY_WIDTH];

  typedef enum logic [1:0] {RX_IDLE, RX_PRE, RX_DATA, RX_DROP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_ERR, TX_DRAIN} tx_state_t;

  rx_state_t      rx_state, rx_state_nxt;
  logic [CW-1:0]  rx_cnt;
  logic [7:0]     rx_shift;
  logic           rx_shift_err;
  logic [7:0]     hold_byte;
  logic           hold_err;
  logic           hold_full;
  logic           rx_shift_en, rx_byte_done, rx_sfd, rx_end, rx_bad_pre;
  logic [7:0]     rx_assembled;

  tx_state_t      tx_state, tx_state_nxt;
  logic [CW-1:0]  tx_idx;
  logic [7:0]     tx_sh;
  logic           tx_err_q, tx_last_q;
  logic           tx_ready, tx_load, tx_uflow;

  // Symbols enter from the top, so after N shifts the first symbol sits in the low bits.
  assign rx_assembled = {phy_rxd_i, rx_shift[7:PHY_WIDTH]};

  // RX next-state and datapath strobes; every decision waits for rx_ce_i.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_shift_en  = 1'b0;
    rx_byte_done = 1'b0;
    rx_sfd       = 1'b0;
    rx_end       = 1'b0;
    rx_bad_pre   = 1'b0;
    if (rx_ce_i) begin
      case (rx_state)
        RX_IDLE: begin
          if (phy_rx_dv_i) begin
            if (ALIGN_SFD) begin
              rx_state_nxt = RX_PRE;
            end else begin
              rx_state_nxt = RX_DATA;
              rx_shift_en  = 1'b1;
            end
          end
        end
        RX_PRE: begin
          if (!phy_rx_dv_i) begin
            rx_state_nxt = RX_IDLE;
          end else if (phy_rx_er_i || (phy_rxd_i != PRE_SYM && phy_rxd_i != SFD_SYM)) begin
            rx_bad_pre   = 1'b1;
            rx_state_nxt = RX_DROP;
          end else if (phy_rxd_i == SFD_SYM) begin
            rx_sfd       = 1'b1;
            rx_state_nxt = RX_DATA;
          end
        end
        RX_DATA: begin
          if (!phy_rx_dv_i) begin
            rx_end       = 1'b1;
            rx_state_nxt = RX_IDLE;
          end else begin
            rx_shift_en  = 1'b1;
            rx_byte_done = (rx_cnt == LAST_IDX);
          end
        end
        RX_DROP: begin
          if (!phy_rx_dv_i) rx_state_nxt = RX_IDLE;
        end
        default: rx_state_nxt = RX_IDLE;
      endcase
    end
  end

  // RX registers: byte assembly, one-byte holding register and the output strobes.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rx_state       <= RX_IDLE;
      rx_cnt         <= '0;
      rx_shift       <= '0;
      rx_shift_err   <= 1'b0;
      hold_byte      <= '0;
      hold_err       <= 1'b0;
      hold_full      <= 1'b0;
      rx_byte_o      <= '0;
      rx_valid_o     <= 1'b0;
      rx_last_o      <= 1'b0;
      rx_err_o       <= 1'b0;
      rx_align_err_o <= 1'b0;
    end else begin
      rx_state       <= rx_state_nxt;
      rx_valid_o     <= 1'b0;
      rx_last_o      <= 1'b0;
      rx_err_o       <= 1'b0;
      rx_align_err_o <= rx_bad_pre;
      if (rx_sfd) begin
        rx_cnt       <= '0;
        rx_shift_err <= 1'b0;
      end
      if (rx_shift_en) begin
        rx_shift <= rx_assembled;
        if (rx_byte_done) begin
          rx_cnt       <= '0;
          rx_shift_err <= 1'b0;
          hold_byte    <= rx_assembled;
          hold_err     <= rx_shift_err | phy_rx_er_i;
          hold_full    <= 1'b1;
          if (hold_full) begin
            rx_byte_o  <= hold_byte;
            rx_valid_o <= 1'b1;
            rx_err_o   <= hold_err;
          end
        end else begin
          rx_cnt       <= rx_cnt + CW'(1);
          rx_shift_err <= rx_shift_err | phy_rx_er_i;
        end
      end
      // A partial byte at dv fall is dropped and taints the final byte.
      if (rx_end) begin
        rx_cnt       <= '0;
        rx_shift_err <= 1'b0;
        hold_full    <= 1'b0;
        if (hold_full) begin
          rx_byte_o  <= hold_byte;
          rx_valid_o <= 1'b1;
          rx_last_o  <= 1'b1;
          rx_err_o   <= hold_err | (rx_cnt != '0);
        end
      end
    end
  end

  // TX next-state, ready and underflow detection.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_ready     = 1'b0;
    tx_uflow     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid_i) tx_state_nxt = TX_SHIFT;
      end
      TX_SHIFT: begin
        if (tx_ce_i && tx_idx == LAST_IDX) begin
          if (tx_last_q) begin
            tx_state_nxt = TX_IDLE;
          end else begin
            tx_ready = 1'b1;
            if (!tx_valid_i) begin
              tx_uflow     = 1'b1;
              tx_state_nxt = TX_ERR;
            end
          end
        end
      end
      TX_ERR: begin
        if (tx_ce_i) tx_state_nxt = TX_DRAIN;
      end
      TX_DRAIN: begin
        tx_ready = 1'b1;
        if (tx_valid_i && tx_last_i) tx_state_nxt = TX_IDLE;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
    tx_load = tx_ready && tx_valid_i && (tx_state == TX_IDLE || tx_state == TX_SHIFT);
  end

  // Ready is held low while reset is asserted so nothing is accepted during reset.
  assign tx_ready_o = rstn_i & tx_ready;

  // TX registers: symbol outputs change only on tx_ce_i and hold in between.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      tx_state       <= TX_IDLE;
      tx_idx         <= '0;
      tx_sh          <= '0;
      tx_err_q       <= 1'b0;
      tx_last_q      <= 1'b0;
      phy_txd_o      <= '0;
      phy_tx_en_o    <= 1'b0;
      phy_tx_er_o    <= 1'b0;
      tx_underflow_o <= 1'b0;
    end else begin
      tx_state       <= tx_state_nxt;
      tx_underflow_o <= tx_uflow;
      if (tx_ce_i) begin
        case (tx_state)
          TX_SHIFT: begin
            phy_txd_o   <= tx_sh[PHY_WIDTH-1:0];
            phy_tx_en_o <= 1'b1;
            phy_tx_er_o <= tx_err_q;
            tx_sh       <= tx_sh >> PHY_WIDTH;
            if (tx_idx != LAST_IDX) tx_idx <= tx_idx + CW'(1);
          end
          TX_ERR: begin
            phy_txd_o   <= '0;
            phy_tx_en_o <= 1'b1;
            phy_tx_er_o <= 1'b1;
          end
          default: begin
            phy_txd_o   <= '0;
            phy_tx_en_o <= 1'b0;
            phy_tx_er_o <= 1'b0;
          end
        endcase
      end
      if (tx_load) begin
        tx_sh     <= tx_byte_i;
        tx_err_q  <= tx_err_i;
        tx_last_q <= tx_last_i;
        tx_idx    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_eth_mii_gearbox.sv
// Bench for eth_mii_gearbox: an MII instance (RX frame table + TX sequences)
// and an RMII instance (hand-written RX frame).
module tb_eth_mii_gearbox;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // MII instance
  logic       rx_ce4, rx_dv4, rx_er4;
  logic [3:0] rxd4;
  logic [7:0] rx_byte4;
  logic       rx_valid4, rx_last4, rx_err4, rx_aerr4;
  logic       tx_ce4, tx_valid4, tx_ready4, tx_last4, tx_err4;
  logic [7:0] tx_byte4;
  logic [3:0] txd4;
  logic       tx_en4, tx_er4, tx_uf4;

  // RMII instance (RX only exercised)
  logic       rx_ce2, rx_dv2, rx_er2;
  logic [1:0] rxd2;
  logic [7:0] rx_byte2;
  logic       rx_valid2, rx_last2, rx_err2, rx_aerr2;
  logic       tx_ce2, tx_valid2, tx_ready2, tx_last2, tx_err2;
  logic [7:0] tx_byte2;
  logic [1:0] txd2;
  logic       tx_en2, tx_er2, tx_uf2;

  eth_mii_gearbox #(.PHY_WIDTH(4), .ALIGN_SFD(1'b1)) dut4 (
    .clk_i(clk), .rstn_i(rstn),
    .rx_ce_i(rx_ce4), .phy_rxd_i(rxd4), .phy_rx_dv_i(rx_dv4), .phy_rx_er_i(rx_er4),
    .rx_byte_o(rx_byte4), .rx_valid_o(rx_valid4), .rx_last_o(rx_last4),
    .rx_err_o(rx_err4), .rx_align_err_o(rx_aerr4),
    .tx_ce_i(tx_ce4), .tx_byte_i(tx_byte4), .tx_valid_i(tx_valid4), .tx_ready_o(tx_ready4),
    .tx_last_i(tx_last4), .tx_err_i(tx_err4),
    .phy_txd_o(txd4), .phy_tx_en_o(tx_en4), .phy_tx_er_o(tx_er4), .tx_underflow_o(tx_uf4)
  );

  eth_mii_gearbox #(.PHY_WIDTH(2), .ALIGN_SFD(1'b1)) dut2 (
    .clk_i(clk), .rstn_i(rstn),
    .rx_ce_i(rx_ce2), .phy_rxd_i(rxd2), .phy_rx_dv_i(rx_dv2), .phy_rx_er_i(rx_er2),
    .rx_byte_o(rx_byte2), .rx_valid_o(rx_valid2), .rx_last_o(rx_last2),
    .rx_err_o(rx_err2), .rx_align_err_o(rx_aerr2),
    .tx_ce_i(tx_ce2), .tx_byte_i(tx_byte2), .tx_valid_i(tx_valid2), .tx_ready_o(tx_ready2),
    .tx_last_i(tx_last2), .tx_err_i(tx_err2),
    .phy_txd_o(txd2), .phy_tx_en_o(tx_en2), .phy_tx_er_o(tx_er2), .tx_underflow_o(tx_uf2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // ---------------- RX scoreboard (MII) ----------------
  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic       err;
  } rx_exp_t;
  rx_exp_t rxq[$];
  int rx_got4 = 0;
  int aerr_cnt4 = 0;
  int v2_cnt = 0;
  int a2_cnt = 0;

  // Pop and compare every byte strobe; count alignment pulses.
  always @(negedge clk) begin
    rx_exp_t e;
    if (rstn) begin
      if (rx_valid4) begin
        rx_got4++;
        if (rxq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_extra_byte: got=%0h want=none", rx_byte4);
        end else begin
          e = rxq.pop_front();
          chk("rx_byte_last_err", 32'({rx_byte4, rx_last4, rx_err4}), 32'({e.b, e.last, e.err}));
        end
      end
      if (rx_aerr4) aerr_cnt4++;
      if (rx_valid2) v2_cnt++;
      if (rx_aerr2) a2_cnt++;
    end
  end

  // ---------------- TX scoreboard (MII) ----------------
  typedef struct packed {
    logic [3:0] d;
    logic       en;
    logic       er;
  } tx_exp_t;
  tx_exp_t txq[$];
  logic tx_arm = 1'b0;
  logic tx_ce_q = 1'b0;
  logic tx_ce_run = 1'b0;
  int   uf_cnt = 0;

  always @(posedge clk) tx_ce_q <= tx_ce4 && tx_arm;

  // Each armed tx_ce_i cycle produces one symbol to compare against the queue.
  always @(negedge clk) begin
    tx_exp_t e;
    if (rstn) begin
      if (tx_ce_q && txq.size() > 0) begin
        e = txq.pop_front();
        chk("tx_symbol", 32'({txd4, tx_en4, tx_er4}), 32'({e.d, e.en, e.er}));
      end
      if (tx_uf4) uf_cnt++;
    end
  end

  // TX enable every 4th clock once running.
  initial begin
    int ph;
    ph = 0;
    tx_ce4 = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_ce_run) begin
        tx_ce4 = (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        tx_ce4 = 1'b0;
      end
    end
  end

  function automatic tx_exp_t mk_tx(input logic [3:0] d, input logic en, input logic er);
    tx_exp_t t;
    t.d = d;
    t.en = en;
    t.er = er;
    return t;
  endfunction

  task automatic tx_send(input logic [7:0] b, input logic last, input logic err,
                         output int waits, output logic on_ce);
    @(negedge clk);
    tx_valid4 = 1'b1;
    tx_byte4  = b;
    tx_last4  = last;
    tx_err4   = err;
    waits = 0;
    #1;
    while (!tx_ready4 && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    on_ce = tx_ce4;
    chk("tx_ready_timeout", 32'(waits < 200), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic tx_idle();
    @(negedge clk);
    tx_valid4 = 1'b0;
    tx_last4  = 1'b0;
    tx_err4   = 1'b0;
  endtask

  task automatic tx_wait_drain();
    int n;
    n = 0;
    while (txq.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("tx_queue_drained", 32'(txq.size()), 32'd0);
  endtask

  // ---------------- RX drivers ----------------
  task automatic sym4(input logic dv, input logic [3:0] d, input logic er);
    @(negedge clk);
    rx_ce4 = 1'b1; rx_dv4 = dv; rxd4 = d; rx_er4 = er;
    @(negedge clk);
    rx_ce4 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic sym2(input logic dv, input logic [1:0] d, input logic er);
    @(negedge clk);
    rx_ce2 = 1'b1; rx_dv2 = dv; rxd2 = d; rx_er2 = er;
    @(negedge clk);
    rx_ce2 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    int          npre;
    int          bad;
    int          bad_sym;
    int          bad_er;
    int          nosfd;
    int          nbytes;
    logic [31:0] data;
    int          dribble;
    int          er_sym;
    int          exp_n;
    int          exp_align;
  } rx_row_t;
  rx_row_t rows[8];

  logic [7:0] c6;

  initial begin
    int w, g0, a0, u0;
    logic oc;
    rx_exp_t e;
    rx_row_t r;

    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, g0, a0, u0;
    logic oc;
    rx_exp_t e;
    rx_row_t r;

    //         npre bad sym er nosfd nb data           drib er_sym exp_n exp_al
    rows[0] = '{15, 0, 0, 0, 0, 3, 32'h00AB3412, 0, -1, 3, 0};
    rows[1] = '{2,  1, 7, 0, 0, 0, 32'h0,        0, -1, 0, 1};
    rows[2] = '{15, 0, 0, 0, 0, 2, 32'h00006655, 0,  1, 2, 0};
    rows[3] = '{15, 0, 0, 0, 0, 2, 32'h00003412, 1, -1, 2, 0};
    rows[4] = '{7,  0, 0, 0, 0, 1, 32'h000000F0, 0, -1, 1, 0};
    rows[5] = '{15, 0, 0, 0, 0, 0, 32'h0,        1, -1, 0, 0};
    rows[6] = '{3,  1, 5, 1, 0, 0, 32'h0,        0, -1, 0, 1};
    rows[7] = '{4,  0, 0, 0, 1, 0, 32'h0,        0, -1, 0, 0};

    rstn = 1'b0;
    rx_ce4 = 0; rx_dv4 = 0; rx_er4 = 0; rxd4 = '0;
    rx_ce2 = 0; rx_dv2 = 0; rx_er2 = 0; rxd2 = '0;
    tx_valid4 = 0; tx_byte4 = '0; tx_last4 = 0; tx_err4 = 0;
    tx_ce2 = 0; tx_valid2 = 0; tx_byte2 = '0; tx_last2 = 0; tx_err2 = 0;
    c6 = 8'hC6;
    repeat (3) @(negedge clk);

    chk("reset_rx_valid", 32'(rx_valid4), 32'd0);
    chk("reset_rx_byte", 32'(rx_byte4), 32'd0);
    chk("reset_rx_align_err", 32'(rx_aerr4), 32'd0);
    chk("reset_txd_en_er", 32'({txd4, tx_en4, tx_er4}), 32'd0);
    chk("reset_underflow", 32'(tx_uf4), 32'd0);
    chk("reset_tx_ready", 32'(tx_ready4), 32'd0);
    chk("reset_rmii_outs", 32'({rx_valid2, rx_byte2, txd2, tx_en2, tx_er2, tx_uf2, tx_ready2}), 32'd0);

    rstn = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_tx_ready", 32'(tx_ready4), 32'd1);
    chk("idle_rmii_tx_ready", 32'(tx_ready2), 32'd1);

    // MII RX frame table
    for (int i = 0; i < 8; i++) begin
      r  = rows[i];
      g0 = rx_got4;
      a0 = aerr_cnt4;
      for (int p = 0; p < r.npre; p++) sym4(1'b1, 4'h5, 1'b0);
      if (r.bad != 0) begin
        sym4(1'b1, r.bad_sym[3:0], r.bad_er != 0);
        sym4(1'b1, 4'h5, 1'b0);
        sym4(1'b1, 4'h5, 1'b0);
      end else if (r.nosfd == 0) begin
        sym4(1'b1, 4'hD, 1'b0);
        for (int k = 0; k < r.nbytes; k++) begin
          e.b    = r.data[8*k +: 8];
          e.last = (k == r.nbytes - 1);
          e.err  = (r.er_sym >= 0 && r.er_sym / 2 == k) || (e.last && r.dribble != 0);
          rxq.push_back(e);
          for (int s = 0; s < 2; s++)
            sym4(1'b1, r.data[8*k + 4*s +: 4], (2*k + s) == r.er_sym);
        end
        if (r.dribble != 0) sym4(1'b1, 4'h9, 1'b0);
      end
      repeat (3) sym4(1'b0, 4'h0, 1'b0);
      chk($sformatf("rx_row%0d_nbytes", i), 32'(rx_got4 - g0), 32'(r.exp_n));
      chk($sformatf("rx_row%0d_align_err", i), 32'(aerr_cnt4 - a0), 32'(r.exp_align));
      chk($sformatf("rx_row%0d_queue_empty", i), 32'(rxq.size()), 32'd0);
    end

    // RMII: 31 preamble dibits, SFD end, byte 0xC6 as dibits 2,1,0,3
    for (int p = 0; p < 31; p++) sym2(1'b1, 2'b01, 1'b0);
    sym2(1'b1, 2'b11, 1'b0);
    for (int s = 0; s < 4; s++) sym2(1'b1, c6[2*s +: 2], 1'b0);
    chk("rmii_held_not_emitted", 32'(v2_cnt), 32'd0);
    @(negedge clk);
    rx_ce2 = 1'b1; rx_dv2 = 1'b0; rxd2 = 2'b00;
    @(negedge clk);
    rx_ce2 = 1'b0;
    chk("rmii_valid_latency", 32'(rx_valid2), 32'd1);
    chk("rmii_byte_last_err", 32'({rx_byte2, rx_last2, rx_err2}), 32'({8'hC6, 1'b1, 1'b0}));
    @(negedge clk);
    chk("rmii_valid_one_cycle", 32'(rx_valid2), 32'd0);
    chk("rmii_align_err", 32'(a2_cnt), 32'd0);

    // TX: 0xA5, 0x3C(last) -> 5, A, C, 3 then enable low
    tx_ce_run = 1'b1;
    u0 = uf_cnt;
    tx_arm = 1'b0;
    txq.push_back(mk_tx(4'h5, 1'b1, 1'b0));
    txq.push_back(mk_tx(4'hA, 1'b1, 1'b0));
    txq.push_back(mk_tx(4'hC, 1'b1, 1'b0));
    txq.push_back(mk_tx(4'h3, 1'b1, 1'b0));
    txq.push_back(mk_tx(4'h0, 1'b0, 1'b0));
    txq.push_back(mk_tx(4'h0, 1'b0, 1'b0));
    tx_send(8'hA5, 1'b0, 1'b0, w, oc);
    chk("tx_ready_in_idle", 32'(w), 32'd0);
    tx_arm = 1'b1;
    tx_send(8'h3C, 1'b1, 1'b0, w, oc);
    chk("tx_ready_on_ce", 32'(oc), 32'd1);
    chk("tx_ready_waited", 32'(w > 0), 32'd1);
    tx_idle();
    tx_wait_drain();
    #1;
    chk("tx_ready_after_last", 32'(tx_ready4), 32'd1);
    chk("tx_no_underflow", 32'(uf_cnt - u0), 32'd0);

    // TX underflow: 0x11 then nothing
    tx_arm = 1'b0;
    txq.push_back(mk_tx(4'h1, 1'b1, 1'b0));
    txq.push_back(mk_tx(4'h1, 1'b1, 1'b0));
    txq.push_back(mk_tx(4'h0, 1'b1, 1'b1));
    txq.push_back(mk_tx(4'h0, 1'b0, 1'b0));
    txq.push_back(mk_tx(4'h0, 1'b0, 1'b0));
    tx_send(8'h11, 1'b0, 1'b0, w, oc);
    tx_arm = 1'b1;
    tx_idle();
    tx_wait_drain();
    chk("tx_underflow_pulse", 32'(uf_cnt - u0), 32'd1);
    // Drain: bytes are swallowed, enable stays low
    txq.push_back(mk_tx(4'h0, 1'b0, 1'b0));
    txq.push_back(mk_tx(4'h0, 1'b0, 1'b0));
    txq.push_back(mk_tx(4'h0, 1'b0, 1'b0));
    tx_send(8'h77, 1'b0, 1'b0, w, oc);
    tx_send(8'h99, 1'b1, 1'b0, w, oc);
    tx_idle();
    tx_wait_drain();
    chk("tx_single_underflow", 32'(uf_cnt - u0), 32'd1);

    // Next frame after abort: 0x5A with tx_err, 0x81 last
    tx_arm = 1'b0;
    txq.push_back(mk_tx(4'hA, 1'b1, 1'b1));
    txq.push_back(mk_tx(4'h5, 1'b1, 1'b1));
    txq.push_back(mk_tx(4'h1, 1'b1, 1'b0));
    txq.push_back(mk_tx(4'h8, 1'b1, 1'b0));
    txq.push_back(mk_tx(4'h0, 1'b0, 1'b0));
    tx_send(8'h5A, 1'b0, 1'b1, w, oc);
    chk("tx_idle_after_drain", 32'(w), 32'd0);
    tx_arm = 1'b1;
    tx_send(8'h81, 1'b1, 1'b0, w, oc);
    tx_idle();
    tx_wait_drain();
    chk("tx_no_underflow_after", 32'(uf_cnt - u0), 32'd1);
    chk("rmii_tx_quiet", 32'({tx_en2, tx_uf2}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
